// File: rtl/cpu_pkg.sv
// Shared CPU datapath types and default sizes.
// Register-file and scoreboard widths derive from these defaults.
package cpu_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xlen_t;

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// Per-register busy bits for in-flight destination writes.
// Issue sets, writeback clears; a same-cycle issue beats the clear.
module busy_scoreboard
  import cpu_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic             issue_en,
  input  logic [AW-1:0]    issue_rd,
  output logic             issue_ready,
  output logic [NREGS-1:0] busy_vec
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;
  logic             w_wr_hit;
  logic             w_accept;

  assign w_wr_hit    = wr_en && (wr_addr == issue_rd);
  assign issue_ready = !r_busy[issue_rd] || w_wr_hit;
  assign w_accept    = issue_en && issue_ready;

  // Set applied after clear so the new producer wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (wr_en)
      w_busy_nxt[wr_addr] = 1'b0;
    if (w_accept)
      w_busy_nxt[issue_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_busy <= '0;
    else
      r_busy <= w_busy_nxt;
  end

  assign busy_vec = r_busy;

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised register file, x0 hardwired, write-to-read bypass,
// with an integrated busy scoreboard for RAW/WAW hazard detection.
module reg_file_sb
  import cpu_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NREAD = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREAD-1:0][AW-1:0]   rs_addr,
  output logic [NREAD-1:0][XLEN-1:0] rs_data,
  output logic [NREAD-1:0]           rs_busy,
  input  logic                       wr_en,
  input  logic [AW-1:0]              wr_addr,
  input  logic [XLEN-1:0]            wr_data,
  input  logic                       issue_en,
  input  logic [AW-1:0]              issue_rd,
  output logic                       issue_ready,
  output logic [NREGS-1:0]           busy_vec
);

  logic [XLEN-1:0] r_regs [1:NREGS-1];
  logic            w_wr_ok;

  assign w_wr_ok = wr_en && (wr_addr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 1; r < NREGS; r++)
        r_regs[r] <= '0;
    end else if (w_wr_ok) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  busy_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .issue_en    (issue_en),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .busy_vec    (busy_vec)
  );

  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic w_zero;
    logic w_hit;

    assign w_zero = (rs_addr[g] == '0);
    assign w_hit  = wr_en && (wr_addr == rs_addr[g]);

    assign rs_data[g] = w_zero ? '0      :
                        w_hit  ? wr_data :
                                 r_regs[rs_addr[g]];

    assign rs_busy[g] = busy_vec[rs_addr[g]] && !w_hit;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: default 32x32 instance plus a
// 16-entry, 3-port, 64-bit instance for the parameter sweep.
module tb_reg_file_sb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0][4:0]  rs_addr;
  logic [1:0][31:0] rs_data;
  logic [1:0]       rs_busy;
  logic             wr_en;
  logic [4:0]       wr_addr;
  logic [31:0]      wr_data;
  logic             issue_en;
  logic [4:0]       issue_rd;
  logic             issue_ready;
  logic [31:0]      busy_vec;

  logic [2:0][3:0]  q_rs_addr;
  logic [2:0][63:0] q_rs_data;
  logic [2:0]       q_rs_busy;
  logic             q_wr_en;
  logic [3:0]       q_wr_addr;
  logic [63:0]      q_wr_data;
  logic             q_issue_en;
  logic [3:0]       q_issue_rd;
  logic             q_issue_ready;
  logic [15:0]      q_busy_vec;

  reg_file_sb dut (
    .clk         (clk),
    .rst         (rst),
    .rs_addr     (rs_addr),
    .rs_data     (rs_data),
    .rs_busy     (rs_busy),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .issue_en    (issue_en),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .busy_vec    (busy_vec)
  );

  reg_file_sb #(
    .XLEN  (64),
    .NREGS (16),
    .NREAD (3)
  ) dut64 (
    .clk         (clk),
    .rst         (rst),
    .rs_addr     (q_rs_addr),
    .rs_data     (q_rs_data),
    .rs_busy     (q_rs_busy),
    .wr_en       (q_wr_en),
    .wr_addr     (q_wr_addr),
    .wr_data     (q_wr_data),
    .issue_en    (q_issue_en),
    .issue_rd    (q_issue_rd),
    .issue_ready (q_issue_ready),
    .busy_vec    (q_busy_vec)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ie;
    logic [4:0]  ir;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        b0;
    logic        b1;
    logic        rdy;
    logic [31:0] bv;
  } vec_t;

  localparam int NV = 18;
  vec_t vt [NV];

  task automatic idle();
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    issue_en = 1'b0;
    issue_rd = '0;
  endtask

  initial begin
    idle();
    rs_addr    = '0;
    q_rs_addr  = '0;
    q_wr_en    = 1'b0;
    q_wr_addr  = '0;
    q_wr_data  = '0;
    q_issue_en = 1'b0;
    q_issue_rd = '0;

    //        we  wa  wd            ie  ir  a0  a1  d0            d1            b0 b1 rdy bv
    vt[0]  = '{0, 0,  32'h0,        0,  0,  0,  5,  32'h0,        32'h0,        0, 0, 1, 32'h0};
    vt[1]  = '{1, 7,  32'h12345678, 0,  0,  7,  0,  32'h12345678, 32'h0,        0, 0, 1, 32'h0};
    vt[2]  = '{0, 0,  32'h0,        0,  0,  7,  0,  32'h12345678, 32'h0,        0, 0, 1, 32'h0};
    vt[3]  = '{1, 0,  32'hFFFFFFFF, 0,  0,  0,  7,  32'h0,        32'h12345678, 0, 0, 1, 32'h0};
    vt[4]  = '{0, 0,  32'h0,        0,  0,  0,  0,  32'h0,        32'h0,        0, 0, 1, 32'h0};
    vt[5]  = '{1, 3,  32'hA5A5A5A5, 0,  0,  7,  3,  32'h12345678, 32'hA5A5A5A5, 0, 0, 1, 32'h0};
    vt[6]  = '{0, 0,  32'h0,        1,  9,  9,  3,  32'h0,        32'hA5A5A5A5, 0, 0, 1, 32'h0};
    vt[7]  = '{0, 0,  32'h0,        1,  9,  9,  0,  32'h0,        32'h0,        1, 0, 0, 32'h200};
    vt[8]  = '{0, 0,  32'h0,        0,  9,  0,  9,  32'h0,        32'h0,        0, 1, 0, 32'h200};
    vt[9]  = '{1, 9,  32'h55,       0,  9,  9,  9,  32'h55,       32'h55,       0, 0, 1, 32'h200};
    vt[10] = '{0, 0,  32'h0,        0,  9,  9,  0,  32'h55,       32'h0,        0, 0, 1, 32'h0};
    vt[11] = '{0, 0,  32'h0,        1,  4,  4,  0,  32'h0,        32'h0,        0, 0, 1, 32'h0};
    vt[12] = '{1, 4,  32'h11,       1,  4,  4,  9,  32'h11,       32'h55,       0, 0, 1, 32'h10};
    vt[13] = '{0, 0,  32'h0,        0,  4,  4,  3,  32'h11,       32'hA5A5A5A5, 1, 0, 0, 32'h10};
    vt[14] = '{1, 4,  32'h22,       0,  4,  4,  7,  32'h22,       32'h12345678, 0, 0, 1, 32'h10};
    vt[15] = '{0, 0,  32'h0,        1,  0,  4,  0,  32'h22,       32'h0,        0, 0, 1, 32'h0};
    vt[16] = '{0, 0,  32'h0,        1,  2,  0,  2,  32'h0,        32'h0,        0, 0, 1, 32'h0};
    vt[17] = '{1, 2,  32'h77,       0,  0,  2,  2,  32'h77,       32'h77,       0, 0, 1, 32'h4};

    // Reset values while rst is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rs_addr[0] = 5'd5;
    rs_addr[1] = 5'd0;
    #1;
    chk("rst_busy_vec", 64'(busy_vec), 64'h0);
    chk("rst_ready", 64'(issue_ready), 64'h1);
    chk("rst_rs_busy", 64'(rs_busy), 64'h0);
    chk("rst_rs_data0", 64'(rs_data[0]), 64'h0);
    rst = 1'b0;

    // Asynchronous reset mid-cycle after writing x5 and issuing x6.
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    issue_en = 1'b1; issue_rd = 5'd6;
    @(posedge clk); #1;
    idle();
    issue_rd = 5'd6;
    rs_addr[0] = 5'd5;
    @(negedge clk);
    chk("pre_rst_x5", 64'(rs_data[0]), 64'hDEADBEEF);
    chk("pre_rst_ready", 64'(issue_ready), 64'h0);
    chk("pre_rst_bv", 64'(busy_vec), 64'h40);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_bv", 64'(busy_vec), 64'h0);
    chk("async_rst_x5", 64'(rs_data[0]), 64'h0);
    chk("async_rst_ready", 64'(issue_ready), 64'h1);
    #1 rst = 1'b0;

    // Table-driven vectors from a clean state.
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      wr_en = vt[i].we; wr_addr = vt[i].wa; wr_data = vt[i].wd;
      issue_en = vt[i].ie; issue_rd = vt[i].ir;
      rs_addr[0] = vt[i].a0; rs_addr[1] = vt[i].a1;
      @(negedge clk);
      chk($sformatf("v%0d_d0", i), 64'(rs_data[0]), 64'(vt[i].d0));
      chk($sformatf("v%0d_d1", i), 64'(rs_data[1]), 64'(vt[i].d1));
      chk($sformatf("v%0d_b0", i), 64'(rs_busy[0]), 64'(vt[i].b0));
      chk($sformatf("v%0d_b1", i), 64'(rs_busy[1]), 64'(vt[i].b1));
      chk($sformatf("v%0d_rdy", i), 64'(issue_ready), 64'(vt[i].rdy));
      chk($sformatf("v%0d_bv", i), 64'(busy_vec), 64'(vt[i].bv));
    end
    @(posedge clk); #1;
    idle();

    // Wide, three-port instance.
    q_wr_en = 1'b1; q_wr_addr = 4'd15; q_wr_data = 64'h0123456789ABCDEF;
    @(posedge clk); #1;
    q_wr_addr = 4'd1; q_wr_data = 64'hFEDCBA9876543210;
    @(posedge clk); #1;
    q_wr_addr = 4'd8; q_wr_data = 64'hAAAA5555AAAA5555;
    @(posedge clk); #1;
    q_wr_addr = 4'd0; q_wr_data = 64'hFFFFFFFFFFFFFFFF;
    @(posedge clk); #1;
    q_wr_en = 1'b0;
    q_rs_addr[0] = 4'd15; q_rs_addr[1] = 4'd1; q_rs_addr[2] = 4'd8;
    @(negedge clk);
    chk("w64_p0_x15", q_rs_data[0], 64'h0123456789ABCDEF);
    chk("w64_p1_x1", q_rs_data[1], 64'hFEDCBA9876543210);
    chk("w64_p2_x8", q_rs_data[2], 64'hAAAA5555AAAA5555);
    chk("w64_busy", 64'(q_rs_busy), 64'h0);
    @(posedge clk); #1;
    q_rs_addr[0] = 4'd8; q_rs_addr[1] = 4'd15; q_rs_addr[2] = 4'd0;
    q_issue_en = 1'b1; q_issue_rd = 4'd15;
    @(negedge clk);
    chk("w64_p0_x8", q_rs_data[0], 64'hAAAA5555AAAA5555);
    chk("w64_p1_x15", q_rs_data[1], 64'h0123456789ABCDEF);
    chk("w64_p2_x0", q_rs_data[2], 64'h0);
    @(posedge clk); #1;
    q_issue_en = 1'b0;
    @(negedge clk);
    chk("w64_bv", 64'(q_busy_vec), 64'h8000);
    chk("w64_rs_busy", 64'(q_rs_busy), 64'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file with an integrated scoreboard, replacing the fixed 2-read/1-write, 32x32 register file in the CPU datapath. It provides NREAD combinational read ports and one writeback port, with the following behaviour:
- register 0 hardwired to zero;
- same-cycle write-to-read bypass;
- asynchronous clear of all registers;
- a per-register busy bit that tracks in-flight destination writes, so the decode stage can detect RAW hazards and stall on WAW.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, >= 2)
- NREAD, 2, number of read ports (>= 1)
- AW, $clog2(NREGS), register address width (derived, not overridden)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- rs_addr  in  NREAD x AW  read addresses
- rs_data  out  NREAD x XLEN  read data
- rs_busy  out  NREAD  1 = addressed register has a pending write
- wr_en  in  1  writeback strobe
- wr_addr  in  AW  writeback destination
- wr_data  in  XLEN  writeback data
- issue_en  in  1  decode issues an instruction writing issue_rd
- issue_rd  in  AW  destination of the issued instruction
- issue_ready  out  1  issue permitted this cycle
- busy_vec  out  NREGS  current busy bits (registered)

## Operation
- Storage: NREGS-1 registers of XLEN bits. Index 0 is not stored; it always reads 0.
- Write: on the clk edge with wr_en=1 and wr_addr!=0, regs[wr_addr] <= wr_data. Writes to index 0 are discarded.
- Read port i (combinational), first match wins:
  - rs_addr[i]==0 -> 0;
  - wr_en && wr_addr==rs_addr[i] -> wr_data (bypass);
  - otherwise regs[rs_addr[i]].
- Read busy, port i: rs_busy[i] = busy[rs_addr[i]] && !(wr_en && wr_addr==rs_addr[i]). Because busy[0] is always 0, rs_busy[i] is 0 for address 0.
- issue_ready = !busy[issue_rd] || (wr_en && wr_addr==issue_rd). This holds for issue_rd==0, since busy[0] is always 0.
- Busy update per register r on the clk edge, in priority order:
  1. r==0 -> 0.
  2. Accepted issue (issue_en && issue_ready && issue_rd==r) -> 1. This includes the case where a writeback to r happens in the same cycle: the new producer wins.
  3. wr_en && wr_addr==r -> 0.
  4. Otherwise hold.
- issue_en with issue_ready=0: ignored, no state change. Decode must hold the instruction and retry.
- Writeback to a non-busy register: data is written, busy stays 0. This is legal and is used for preloading.
- Reset (asynchronous, any cycle, including mid-writeback): all regs <= 0 and all busy <= 0 immediately. Combinational outputs follow from the cleared state plus the current inputs.

## Timing
- Read latency 0: rs_data and rs_busy are combinational from rs_addr, the write port and state.
- Write-to-read latency 0 via bypass. The stored value is visible from the cycle after the edge.
- An issued destination reads busy from the next cycle. Same-cycle reads of issue_rd do not see the pending issue.
- Writeback clears busy combinationally on rs_busy and issue_ready in the same cycle, and in state at the edge.
- busy_vec is registered. It reflects state only, not the same-cycle bypass.
- Reset values:
  - regs 0, busy_vec 0;
  - issue_ready 1;
  - rs_busy 0;
  - rs_data 0 unless bypass is active.

## Structure
- Shared package cpu_pkg: XLEN default, NREGS default, typedef reg_addr_t (logic [AW-1:0]), typedef xlen_t (logic [XLEN-1:0]).
- Sub-module busy_scoreboard holds:
  - NREGS busy flops with asynchronous reset;
  - the set/clear priority logic;
  - issue_ready.

  reg_file_sb instantiates it and keeps the data array, the bypass muxes and the read-port generate loop.
- The data array uses asynchronous reset on every entry; no memory macro.

## Test plan
- Reset: assert rst mid-cycle after writing x5=0xDEADBEEF -> immediately busy_vec=0, reading x5 returns 0, issue_ready=1.
- Write/read/x0:
  - write x7=0x12345678, next cycle rs_addr[0]=7 -> 0x12345678;
  - write x0=0xFFFFFFFF -> reading x0 returns 0, busy_vec[0]=0.
- Bypass: wr_en, wr_addr=3, wr_data=0xA5A5A5A5 while rs_addr[1]=3 -> same-cycle rs_data[1]=0xA5A5A5A5, rs_busy[1]=0.
- Scoreboard:
  - issue x9 -> next cycle busy_vec[9]=1 and rs_busy=1 on a port reading x9;
  - issue x9 again -> issue_ready=0 and the issue is ignored;
  - writeback x9=0x55 -> same cycle issue_ready=1, next cycle busy_vec[9]=0 and x9 reads 0x55.
- Simultaneous issue and writeback: x4 busy; in one cycle wr x4=0x11 and issue x4 -> next cycle busy_vec[4]=1 and x4 reads 0x11.
- Parameter sweep: NREGS=16, NREAD=3, XLEN=64 -> all three ports read independent registers correctly, and a write of 0x0123456789ABCDEF to x15 reads back intact.
